grid_cursor_painter: RTL and testbench
======================================

Name: grid_cursor_painter

Overview:
- Parametrised successor to the tower-placer grid datapath.
- Holds a COLS x ROWS cursor, a per-cell occupancy map and a pixel scanner.
- Moves the cursor in four directions with wrap, and places or removes towers with occupancy checking.
- Streams cell pixels (erase outline, draw outline, fill interior) to the VGA writer over a valid/ready handshake.

Parameters:
COLS, 8, grid columns (>=2)
ROWS, 6, grid rows (>=2)
CELL, 20, cell edge in pixels (>=3)
XW, 8, x coordinate width; COLS*CELL <= 2^XW
YW, 7, y coordinate width; ROWS*CELL <= 2^YW
CW, 9, colour width
CUR_COLOUR, 9'h1FF, cursor outline colour
BG_COLOUR, 9'h000, background colour
TWR_COLOUR, 9'h1C0, tower fill colour

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd  in  3  0 nop, 1 right, 2 left, 3 down, 4 up, 5 place, 6 remove, 7 home
cmd_ready  out  1  high only in IDLE
px_valid  out  1  pixel offered
px_ready  in  1  VGA writer accepts pixel
px_x  out  XW  pixel x
px_y  out  YW  pixel y
px_colour  out  CW  pixel colour
cur_col  out  clog2(COLS)  cursor column
cur_row  out  clog2(ROWS)  cursor row
occupied  out  1  occupancy bit of cursor cell
place_ok  out  1  one-cycle pulse: place/remove succeeded
reject  out  1  one-cycle pulse: place/remove refused
busy  out  1  state != IDLE

Behaviour:
- Reset (asynchronous, immediate): cursor (0,0); occupancy all 0; state IDLE; px_valid, place_ok, reject, busy = 0; px_x, px_y, px_colour = 0. Reset mid-stream drops px_valid at once. No pixels are emitted after reset until a command arrives.
- Accept: a command is taken when cmd_valid && cmd_ready. cmd is sampled on that edge only.
- FSM states: IDLE, ERASE, MOVE, OUTLINE, FILL, DONE.
- Scanner: a SCAN state walks offsets (dx,dy), dx fastest, 0..CELL-1 each, one offset per cycle.
  - Border offset: dx or dy equals 0 or CELL-1. Interior offset: all others.
  - OUTLINE/ERASE emit border offsets only; FILL emits interior offsets only.
  - Non-emitted offsets are skipped silently in 1 cycle.
  - While emitting, px_valid=1 and px_x/px_y/px_colour hold stable until px_ready. The offset advances on the handshake.
  - Pixel address: px_x = col*CELL+dx, px_y = row*CELL+dy, computed at full width, no truncation given the parameter rule.
  - Outline emits 4*CELL-4 pixels; fill emits (CELL-2)^2.
- nop: accepted, no effect; stays IDLE.
- Moves (1-4): ERASE the old cell outline in BG_COLOUR → MOVE (1 cycle, update cursor) → OUTLINE the new cell in CUR_COLOUR → DONE → IDLE.
  - Wrap: right at COLS-1 → 0; left at 0 → COLS-1; down at ROWS-1 → 0; up at 0 → ROWS-1.
- home: as a move with target (0,0). Home while already at (0,0) still erases and redraws.
- place: if the cell is free, set its bit → FILL in TWR_COLOUR → OUTLINE in CUR_COLOUR → DONE (place_ok pulse) → IDLE. If the cell is occupied: reject pulse in DONE, no pixels emitted.
- remove: if the cell is occupied, clear its bit → FILL in BG_COLOUR → OUTLINE → DONE (place_ok) → IDLE. If the cell is free: reject, no pixels.
- occupied reflects the current cursor cell combinationally from registered state. Occupancy updates on the accept edge.
- Latency: first px_valid is asserted the cycle after accept when offset (0,0) is emitted. With px_ready tied high, a move takes 2*CELL*CELL + 3 cycles from accept to cmd_ready.
- DONE lasts exactly 1 cycle.
- cmd_valid while busy is ignored: it is not queued and not lost, because the source must hold it.
- px_ready low stalls the scan indefinitely. State and coordinates stay frozen.

Test Plan:
- Reset, then cmd=1 with px_ready=1 → 76 pixels at x 0..19/y 0..19 border in 9'h000, then 76 border pixels at x 20..39 in 9'h1FF; cur_col=1; cmd_ready returns after 803 cycles.
- From (7,0), cmd=1 → cur_col=0. From (0,0), cmd=4 → cur_row=5, with outline y range 100..119.
- place at (2,3) → place_ok; 324 pixels in 9'h1C0 with x 41..58, y 61..78; then 76 outline pixels; occupied=1. A second place at the same cell → reject, zero pixels.
- remove at a free cell → reject, no px_valid. remove at an occupied cell → 324 BG pixels, occupied=0.
- Toggle px_ready randomly during a move → each pixel is accepted exactly once, with values held stable while stalled; the pixel count matches the px_ready=1 case.
- Assert resetn low mid-fill → px_valid=0 immediately; cursor (0,0); all occupancy 0; cmd_ready=1 after release.

Source files
------------

// File: rtl/grid_cursor_painter_if.sv
// Command and pixel-stream bundle between the command source / VGA writer
// and grid_cursor_painter.
//   cmd_valid/cmd/cmd_ready           : command handshake (painter is the sink)
//   px_valid/px_ready/px_x/px_y/px_colour : pixel stream (painter is the source)
// master : command source + VGA writer side
// slave  : painter side
interface grid_cursor_painter_if #(
  parameter int XW = 8,
  parameter int YW = 7,
  parameter int CW = 9
);
  logic          cmd_valid;
  logic [2:0]    cmd;
  logic          cmd_ready;
  logic          px_valid;
  logic          px_ready;
  logic [XW-1:0] px_x;
  logic [YW-1:0] px_y;
  logic [CW-1:0] px_colour;

  modport master (
    output cmd_valid, cmd, px_ready,
    input  cmd_ready, px_valid, px_x, px_y, px_colour
  );

  modport slave (
    input  cmd_valid, cmd, px_ready,
    output cmd_ready, px_valid, px_x, px_y, px_colour
  );
endinterface

// File: rtl/grid_cursor_painter.sv
// Grid cursor painter: COLS x ROWS cursor with wrap, per-cell tower occupancy
// map, and a cell pixel scanner streaming erase/outline/fill pixels.
// Ports:
//   clk, resetn : clock, asynchronous active-low reset
//   bus         : command handshake and pixel stream (slave modport)
//   cur_col/row : cursor position
//   occupied    : occupancy bit of the cursor cell
//   place_ok    : one-cycle pulse, place/remove succeeded
//   reject      : one-cycle pulse, place/remove refused
//   busy        : command in progress
module grid_cursor_painter #(
  parameter int          COLS       = 8,
  parameter int          ROWS       = 6,
  parameter int          CELL       = 20,
  parameter int          XW         = 8,
  parameter int          YW         = 7,
  parameter int          CW         = 9,
  parameter logic [CW-1:0] CUR_COLOUR = 9'h1FF,
  parameter logic [CW-1:0] BG_COLOUR  = 9'h000,
  parameter logic [CW-1:0] TWR_COLOUR = 9'h1C0,
  localparam int         CCW        = $clog2(COLS),
  localparam int         RCW        = $clog2(ROWS)
) (
  input  logic                 clk,
  input  logic                 resetn,
  grid_cursor_painter_if.slave bus,
  output logic [CCW-1:0]       cur_col,
  output logic [RCW-1:0]       cur_row,
  output logic                 occupied,
  output logic                 place_ok,
  output logic                 reject,
  output logic                 busy
);
  localparam int DW = $clog2(CELL);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ERASE   = 3'd1;
  localparam logic [2:0] S_MOVE    = 3'd2;
  localparam logic [2:0] S_OUTLINE = 3'd3;
  localparam logic [2:0] S_FILL    = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic [2:0] C_NOP    = 3'd0;
  localparam logic [2:0] C_RIGHT  = 3'd1;
  localparam logic [2:0] C_LEFT   = 3'd2;
  localparam logic [2:0] C_DOWN   = 3'd3;
  localparam logic [2:0] C_UP     = 3'd4;
  localparam logic [2:0] C_PLACE  = 3'd5;
  localparam logic [2:0] C_REMOVE = 3'd6;
  localparam logic [2:0] C_HOME   = 3'd7;

  localparam logic [DW-1:0]  D_LAST = DW'(CELL - 1);
  localparam logic [CCW-1:0] C_LAST = CCW'(COLS - 1);
  localparam logic [RCW-1:0] R_LAST = RCW'(ROWS - 1);

  logic [2:0]               state;
  logic [2:0]               op;
  logic                     ok_flag;
  logic [DW-1:0]            dx;
  logic [DW-1:0]            dy;
  logic [ROWS-1:0][COLS-1:0] occ;

  logic          border;
  logic          last_off;
  logic          scanning;
  logic          emit;
  logic          step;
  logic [2:0]    scan_next;
  logic [CW-1:0] colour;

  always_comb begin
    border   = (dx == '0) || (dx == D_LAST) || (dy == '0) || (dy == D_LAST);
    last_off = (dx == D_LAST) && (dy == D_LAST);
    scanning = (state == S_ERASE) || (state == S_OUTLINE) || (state == S_FILL);
    emit     = 1'b0;
    colour   = BG_COLOUR;
    scan_next = S_DONE;
    case (state)
      S_ERASE: begin
        emit      = border;
        colour    = BG_COLOUR;
        scan_next = S_MOVE;
      end
      S_OUTLINE: begin
        emit      = border;
        colour    = CUR_COLOUR;
        scan_next = S_DONE;
      end
      S_FILL: begin
        emit      = !border;
        colour    = (op == C_PLACE) ? TWR_COLOUR : BG_COLOUR;
        scan_next = S_OUTLINE;
      end
      default: ;
    endcase
    // Skipped offsets advance unconditionally; emitted ones wait for px_ready.
    step = scanning && (!emit || bus.px_ready);
  end

  assign occupied      = occ[cur_row][cur_col];
  assign busy          = (state != S_IDLE);
  assign bus.cmd_ready = (state == S_IDLE);
  assign bus.px_valid  = emit;
  assign bus.px_x      = emit ? XW'(cur_col) * XW'(CELL) + XW'(dx) : '0;
  assign bus.px_y      = emit ? YW'(cur_row) * YW'(CELL) + YW'(dy) : '0;
  assign bus.px_colour = emit ? colour : '0;
  assign place_ok      = (state == S_DONE) && ok_flag;
  assign reject        = (state == S_DONE) && !ok_flag &&
                         ((op == C_PLACE) || (op == C_REMOVE));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      op      <= C_NOP;
      ok_flag <= 1'b0;
      dx      <= '0;
      dy      <= '0;
      cur_col <= '0;
      cur_row <= '0;
      occ     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            op      <= bus.cmd;
            ok_flag <= 1'b0;
            dx      <= '0;
            dy      <= '0;
            case (bus.cmd)
              C_NOP: ;
              C_PLACE: begin
                if (!occupied) begin
                  occ[cur_row][cur_col] <= 1'b1;
                  ok_flag <= 1'b1;
                  state   <= S_FILL;
                end else begin
                  state <= S_DONE;
                end
              end
              C_REMOVE: begin
                if (occupied) begin
                  occ[cur_row][cur_col] <= 1'b0;
                  ok_flag <= 1'b1;
                  state   <= S_FILL;
                end else begin
                  state <= S_DONE;
                end
              end
              default: state <= S_ERASE;
            endcase
          end
        end
        S_ERASE, S_OUTLINE, S_FILL: begin
          if (step) begin
            if (last_off) begin
              dx    <= '0;
              dy    <= '0;
              state <= scan_next;
            end else if (dx == D_LAST) begin
              dx <= '0;
              dy <= dy + DW'(1);
            end else begin
              dx <= dx + DW'(1);
            end
          end
        end
        S_MOVE: begin
          case (op)
            C_RIGHT: cur_col <= (cur_col == C_LAST) ? '0 : cur_col + CCW'(1);
            C_LEFT:  cur_col <= (cur_col == '0) ? C_LAST : cur_col - CCW'(1);
            C_DOWN:  cur_row <= (cur_row == R_LAST) ? '0 : cur_row + RCW'(1);
            C_UP:    cur_row <= (cur_row == '0) ? R_LAST : cur_row - RCW'(1);
            default: begin
              cur_col <= '0;
              cur_row <= '0;
            end
          endcase
          state <= S_OUTLINE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_grid_cursor_painter.sv
module tb_grid_cursor_painter;
  localparam int COLS = 8;
  localparam int ROWS = 6;
  localparam int CELL = 20;
  localparam int BG   = 9'h000;
  localparam int CUR  = 9'h1FF;
  localparam int TWR  = 9'h1C0;
  localparam int LIMIT = 20000;

  typedef struct { int x; int y; int c; } pix_t;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [2:0] cur_col;
  logic [2:0] cur_row;
  logic       occupied, place_ok, reject, busy;
  logic       stall_en = 1'b0;

  grid_cursor_painter_if #(.XW(8), .YW(7), .CW(9)) pif ();

  grid_cursor_painter #(
    .COLS(COLS), .ROWS(ROWS), .CELL(CELL), .XW(8), .YW(7), .CW(9),
    .CUR_COLOUR(9'h1FF), .BG_COLOUR(9'h000), .TWR_COLOUR(9'h1C0)
  ) dut (
    .clk(clk), .resetn(resetn), .bus(pif),
    .cur_col(cur_col), .cur_row(cur_row), .occupied(occupied),
    .place_ok(place_ok), .reject(reject), .busy(busy)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  pix_t exp_q[$];
  int   res_q[$];
  bit   occ_m[ROWS][COLS];
  int   mc = 0;
  int   mr = 0;
  pix_t mon_e;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Raster-order pixels of one cell: border ring or interior only.
  task automatic push_cell(input int c, input int r, input bit interior, input int colour);
    for (int y = 0; y < CELL; y++)
      for (int x = 0; x < CELL; x++) begin
        bit on_edge = (x == 0) || (y == 0) || (x == CELL - 1) || (y == CELL - 1);
        if (on_edge != interior) exp_q.push_back('{c * CELL + x, r * CELL + y, colour});
      end
  endtask

  task automatic model_reset();
    exp_q.delete();
    res_q.delete();
    mc = 0;
    mr = 0;
    foreach (occ_m[r, c]) occ_m[r][c] = 1'b0;
  endtask

  task automatic model_cmd(input int c, output int lat);
    lat = 1;
    case (c)
      0: lat = 1;
      5, 6: begin
        if (occ_m[mr][mc] == (c == 6)) begin
          occ_m[mr][mc] = (c == 5);
          push_cell(mc, mr, 1'b1, (c == 5) ? TWR : BG);
          push_cell(mc, mr, 1'b0, CUR);
          res_q.push_back(1);
          lat = 2 * CELL * CELL + 2;
        end else begin
          res_q.push_back(0);
          lat = 2;
        end
      end
      default: begin
        push_cell(mc, mr, 1'b0, BG);
        case (c)
          1: mc = (mc + 1) % COLS;
          2: mc = (mc + COLS - 1) % COLS;
          3: mr = (mr + 1) % ROWS;
          4: mr = (mr + ROWS - 1) % ROWS;
          default: begin mc = 0; mr = 0; end
        endcase
        push_cell(mc, mr, 1'b0, CUR);
        lat = 2 * CELL * CELL + 3;
      end
    endcase
  endtask

  // Monitor: every offered pixel must equal the scoreboard head, held until taken.
  always @(negedge clk) begin
    if (resetn) begin
      if (pif.px_valid) begin
        if (exp_q.size() == 0) check("px_extra", 1, 0);
        else begin
          mon_e = exp_q[0];
          check("px_x", int'(pif.px_x), mon_e.x);
          check("px_y", int'(pif.px_y), mon_e.y);
          check("px_colour", int'(pif.px_colour), mon_e.c);
          if (pif.px_ready) void'(exp_q.pop_front());
        end
      end
      if (place_ok || reject) begin
        if (res_q.size() == 0) check("result_extra", 1, 0);
        else begin
          check("result_kind", int'(place_ok), res_q[0]);
          check("result_excl", int'(place_ok & reject), 0);
          void'(res_q.pop_front());
        end
      end
    end
  end

  initial begin
    pif.px_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 pif.px_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic post_checks();
    check("cur_col", int'(cur_col), mc);
    check("cur_row", int'(cur_row), mr);
    check("occupied", int'(occupied), int'(occ_m[mr][mc]));
    check("px_left", exp_q.size(), 0);
    check("res_left", res_q.size(), 0);
  endtask

  task automatic do_cmd(input int c);
    int lat;
    int cyc;
    @(negedge clk);
    check("ready_before", int'(pif.cmd_ready), 1);
    model_cmd(c, lat);
    pif.cmd_valid = 1'b1;
    pif.cmd = 3'(c);
    @(posedge clk);
    #1;
    pif.cmd_valid = 1'b0;
    pif.cmd = 3'($urandom);
    cyc = 1;
    while (!pif.cmd_ready && cyc < LIMIT) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (cyc >= LIMIT) check("ready_timeout", cyc, lat);
    else if (!stall_en) check("latency", cyc, lat);
    post_checks();
  endtask

  initial begin
    #(900000 * 10);
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    pif.cmd_valid = 1'b0;
    pif.cmd = 3'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", int'(pif.cmd_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(pif.px_valid), 0);
    check("rst_px_x", int'(pif.px_x), 0);
    check("rst_px_y", int'(pif.px_y), 0);
    check("rst_colour", int'(pif.px_colour), 0);
    check("rst_ok", int'(place_ok), 0);
    check("rst_reject", int'(reject), 0);
    @(negedge clk) resetn = 1'b1;
    repeat (20) @(posedge clk);
    post_checks();

    // Directed: moves, wrap, home, place/remove.
    do_cmd(1);
    do_cmd(2);
    do_cmd(2);          // (7,0)
    do_cmd(1);          // wrap to col 0
    do_cmd(4);          // wrap to row 5
    do_cmd(7);
    do_cmd(7);          // home at home still redraws
    do_cmd(0);
    do_cmd(1); do_cmd(1); do_cmd(3); do_cmd(3); do_cmd(3);   // (2,3)
    do_cmd(5);
    do_cmd(5);          // reject
    do_cmd(1);
    do_cmd(6);          // reject, free cell
    do_cmd(2);
    do_cmd(6);          // remove ok
    do_cmd(5);          // occupy (2,3) again for the reset test
    do_cmd(1); do_cmd(4);   // (3,2)

    // Reset in the middle of a fill.
    @(negedge clk);
    model_cmd(5, lat);
    pif.cmd_valid = 1'b1;
    pif.cmd = 3'd5;
    @(posedge clk);
    #1 pif.cmd_valid = 1'b0;
    repeat (60) @(posedge clk);
    #2 resetn = 1'b0;
    model_reset();
    #1;
    check("mid_rst_valid", int'(pif.px_valid), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_col", int'(cur_col), 0);
    check("mid_rst_row", int'(cur_row), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk);
    #1 check("rel_ready", int'(pif.cmd_ready), 1);
    do_cmd(1); do_cmd(1); do_cmd(3); do_cmd(3); do_cmd(3);
    do_cmd(2);
    do_cmd(5);          // (1,3) free after reset
    do_cmd(1);
    do_cmd(5);          // (2,3) cleared by reset
    do_cmd(1); do_cmd(4);
    do_cmd(5);          // (3,2) cleared by reset

    // Randomised commands with random back-pressure.
    for (int i = 0; i < 24; i++) begin
      stall_en = 1'($urandom_range(0, 1));
      do_cmd(int'($urandom_range(0, 7)));
    end
    stall_en = 1'b0;
    do_cmd(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
